ball_court: RTL and testbench

- Upstream ball engine for the tennis/squash game.
- Moves a one-hot ball along a COURT_LEN-cell LED row between player 1 (cell 0) and player 2 (cell COURT_LEN-1).
- Generates the per-player hittable_ball windows that feed the two player blocks, and consumes their return and match outputs.
- In squash mode the player-2 end is a wall and only player 1 plays.

---
 rtl/ball_court.sv | 180 ++++++++++++++++++
 tb/tb_ball_court.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ball_court.sv
// Ball engine: moves a one-hot ball between two player ends, decodes hit windows and exits.
// Optional macro BALL_COURT_SPEEDUP_EN shortens the step period on each valid return.
module ball_court #(
    parameter int COURT_LEN  = 16,
    parameter int HIT_ZONE   = 2,
    parameter int TICK_DIV   = 12500000,
    parameter int MIN_DIV    = 2500000,
    parameter int SPEED_STEP = 500000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_game,
    input  logic                 squash_en,
    input  logic                 serve,
    input  logic                 return_p1,
    input  logic                 return_p2,
    input  logic                 match_p1,
    input  logic                 match_p2,
    output logic                 hittable_p1,
    output logic                 hittable_p2,
    output logic [COURT_LEN-1:0] ball_pos,
    output logic                 ball_dir,
    output logic [7:0]           rally_cnt,
    output logic                 point_over
);

    // state      | meaning
    // S_IDLE     | no game, ball hidden
    // S_SERVE    | ball parked at server's end, waiting for serve
    // S_TRAVEL   | ball stepping along the court
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SERVE  = 2'd1;
    localparam logic [1:0] S_TRAVEL = 2'd2;

    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int AW = $clog2(COURT_LEN);

    localparam logic [AW-1:0] LAST   = AW'(COURT_LEN - 1);
    localparam logic [AW-1:0] HZ_LO  = AW'(HIT_ZONE);
    localparam logic [AW-1:0] HZ_HI  = AW'(COURT_LEN - HIT_ZONE);
    localparam logic [PW-1:0] TICK_P = PW'(TICK_DIV);

    logic [1:0]    state_q,  state_d;
    logic [AW-1:0] pos_q,    pos_d;
    logic          dir_q,    dir_d;
    logic          server_q, server_d;
    logic [7:0]    rally_q,  rally_d;
    logic [PW-1:0] period_q, period_d;
    logic [PW-1:0] cnt_q,    cnt_d;
    logic          point_q,  point_d;

    logic          hit1, hit2, ret_ok, tick;
    logic [PW-1:0] period_ret;

`ifdef BALL_COURT_SPEEDUP_EN
    localparam logic [PW-1:0] MIN_P  = PW'(MIN_DIV);
    localparam logic [PW-1:0] STEP_P = PW'(SPEED_STEP);
    // period never drops below MIN_P, so the subtraction below cannot wrap
    assign period_ret = ((period_q - MIN_P) >= STEP_P) ? (period_q - STEP_P) : MIN_P;
`else
    logic unused_speed_params;
    assign unused_speed_params = ^{MIN_DIV, SPEED_STEP};
    assign period_ret = period_q;
`endif

    assign hit1   = (state_q == S_TRAVEL) && !dir_q && (pos_q < HZ_LO);
    assign hit2   = (state_q == S_TRAVEL) && dir_q && (pos_q >= HZ_HI) && !squash_en;
    assign ret_ok = (return_p1 && hit1) || (return_p2 && hit2);
    assign tick   = (cnt_q == (period_q - PW'(1)));

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        server_d = server_q;
        rally_d  = rally_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        point_d  = 1'b0;

        if (!start_game || match_p1 || match_p2) begin
            state_d  = S_IDLE;
            pos_d    = '0;
            dir_d    = 1'b1;
            server_d = 1'b0;
            rally_d  = '0;
            period_d = TICK_P;
            cnt_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d  = S_SERVE;
                    server_d = 1'b0;
                    pos_d    = '0;
                    dir_d    = 1'b1;
                end
                S_SERVE: begin
                    if (serve) begin
                        state_d  = S_TRAVEL;
                        dir_d    = !server_q;
                        rally_d  = '0;
                        period_d = TICK_P;
                        cnt_d    = '0;
                    end
                end
                S_TRAVEL: begin
                    if (ret_ok) begin
                        dir_d    = !dir_q;
                        cnt_d    = '0;
                        rally_d  = (rally_q == 8'hFF) ? rally_q : rally_q + 8'd1;
                        period_d = period_ret;
                    end else if (tick) begin
                        cnt_d = '0;
                        if (!dir_q && pos_q == '0) begin
                            state_d  = S_SERVE;
                            point_d  = 1'b1;
                            server_d = 1'b0;
                            pos_d    = '0;
                        end else if (dir_q && pos_q == LAST) begin
                            if (squash_en) begin
                                dir_d = 1'b0;
                                pos_d = LAST - AW'(1);
                            end else begin
                                state_d  = S_SERVE;
                                point_d  = 1'b1;
                                server_d = 1'b1;
                                pos_d    = LAST;
                            end
                        end else begin
                            pos_d = dir_q ? pos_q + AW'(1) : pos_q - AW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + PW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // squash mode has no player 2, so any pending p2 serve reverts to p1
            if (state_d == S_SERVE && state_q != S_SERVE && squash_en) begin
                server_d = 1'b0;
                pos_d    = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            pos_q    <= '0;
            dir_q    <= 1'b1;
            server_q <= 1'b0;
            rally_q  <= '0;
            period_q <= TICK_P;
            cnt_q    <= '0;
            point_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            server_q <= server_d;
            rally_q  <= rally_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            point_q  <= point_d;
        end
    end

    always_comb begin
        ball_pos = '0;
        if (state_q != S_IDLE) ball_pos[pos_q] = 1'b1;
    end

    assign hittable_p1 = hit1;
    assign hittable_p2 = hit2;
    assign ball_dir    = dir_q;
    assign rally_cnt   = rally_q;
    assign point_over  = point_q;

endmodule

// File: tb/tb_ball_court.sv
// Directed vector bench for ball_court on an 8-cell court with a 4-cycle step period.
module tb_ball_court;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_game = 1'b0, squash_en = 1'b0, serve = 1'b0;
    logic       return_p1 = 1'b0, return_p2 = 1'b0, match_p1 = 1'b0, match_p2 = 1'b0;
    logic       hittable_p1, hittable_p2, ball_dir, point_over;
    logic [7:0] ball_pos, rally_cnt;

    int total = 0;
    int bad   = 0;
    int step_after_ret;
    logic saw_h2;

    ball_court #(
        .COURT_LEN(8), .HIT_ZONE(2), .TICK_DIV(4), .MIN_DIV(2), .SPEED_STEP(1)
    ) dut (
        .clk(clk), .rst(rst), .start_game(start_game), .squash_en(squash_en),
        .serve(serve), .return_p1(return_p1), .return_p2(return_p2),
        .match_p1(match_p1), .match_p2(match_p2),
        .hittable_p1(hittable_p1), .hittable_p2(hittable_p2),
        .ball_pos(ball_pos), .ball_dir(ball_dir),
        .rally_cnt(rally_cnt), .point_over(point_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       st, sq, sv, r1, r2, m1;
        int         edges;
        logic [7:0] pos;
        logic       cdir, dir;
        logic [7:0] rc;
        logic       pt, h1, h2;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic st, sq, sv, r1, r2, m1, input int ed,
                       input logic [7:0] pos, input logic cdir, dir, input logic [7:0] rc,
                       input logic pt, h1, h2);
        vec_t v;
        v.name = nm; v.st = st; v.sq = sq; v.sv = sv; v.r1 = r1; v.r2 = r2; v.m1 = m1;
        v.edges = ed; v.pos = pos; v.cdir = cdir; v.dir = dir; v.rc = rc;
        v.pt = pt; v.h1 = h1; v.h2 = h2;
        vq.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        start_game = v.st; squash_en = v.sq; serve = v.sv;
        return_p1 = v.r1; return_p2 = v.r2; match_p1 = v.m1;
        for (int e = 0; e < v.edges; e++) begin
            @(posedge clk); #1;
            if (squash_en && hittable_p2) saw_h2 = 1'b1;
            if (e == 0) begin
                serve = 1'b0; return_p1 = 1'b0; return_p2 = 1'b0; match_p1 = 1'b0;
            end
        end
        chk({v.name, " ball_pos"}, int'(ball_pos), int'(v.pos));
        chk({v.name, " rally_cnt"}, int'(rally_cnt), int'(v.rc));
        chk({v.name, " point_over"}, int'(point_over), int'(v.pt));
        chk({v.name, " hittable_p1"}, int'(hittable_p1), int'(v.h1));
        chk({v.name, " hittable_p2"}, int'(hittable_p2), int'(v.h2));
        if (v.cdir) chk({v.name, " ball_dir"}, int'(ball_dir), int'(v.dir));
    endtask

    initial begin
`ifdef BALL_COURT_SPEEDUP_EN
        step_after_ret = 3;
`else
        step_after_ret = 4;
`endif
        saw_h2 = 1'b0;

        //  name           st sq sv r1 r2 m1 edges            pos    cd dir rc  pt h1 h2
        add("serve_wait",  1, 0, 0, 0, 0, 0, 1,               8'h01, 0, 0,  0, 0, 0, 0);
        add("no_step_sw",  1, 0, 0, 0, 0, 0, 4,               8'h01, 0, 0,  0, 0, 0, 0);
        add("serve",       1, 0, 1, 0, 0, 0, 1,               8'h01, 1, 1,  0, 0, 0, 0);
        add("cnt3_pos0",   1, 0, 0, 0, 0, 0, 3,               8'h01, 1, 1,  0, 0, 0, 0);
        add("step1",       1, 0, 0, 0, 0, 0, 1,               8'h02, 1, 1,  0, 0, 0, 0);
        add("step2",       1, 0, 0, 0, 0, 0, 4,               8'h04, 1, 1,  0, 0, 0, 0);
        add("step5",       1, 0, 0, 0, 0, 0, 12,              8'h20, 1, 1,  0, 0, 0, 0);
        add("pre_zone",    1, 0, 0, 0, 0, 0, 3,               8'h20, 1, 1,  0, 0, 0, 0);
        add("zone_p2_in",  1, 0, 0, 0, 0, 0, 1,               8'h40, 1, 1,  0, 0, 0, 1);
        add("zone_p2_end", 1, 0, 0, 0, 0, 0, 4,               8'h80, 1, 1,  0, 0, 0, 1);
        add("return_p2",   1, 0, 0, 1, 1, 0, 1,               8'h80, 1, 0,  1, 0, 0, 0);
        add("ret_no_step", 1, 0, 0, 0, 0, 0, step_after_ret-1, 8'h80, 1, 0, 1, 0, 0, 0);
        add("ret_step",    1, 0, 0, 0, 0, 0, 1,               8'h40, 1, 0,  1, 0, 0, 0);
        add("back_pos2",   1, 0, 0, 0, 0, 0, 4*step_after_ret, 8'h04, 1, 0, 1, 0, 0, 0);
        add("zone_p1_in",  1, 0, 0, 0, 0, 0, step_after_ret,  8'h02, 1, 0,  1, 0, 1, 0);
        add("zone_p1_end", 1, 0, 0, 0, 0, 0, step_after_ret,  8'h01, 1, 0,  1, 0, 1, 0);
        add("pre_exit",    1, 0, 0, 0, 0, 0, step_after_ret-1, 8'h01, 1, 0, 1, 0, 1, 0);
        add("exit_p1",     1, 0, 0, 0, 0, 0, 1,               8'h01, 0, 0,  1, 1, 0, 0);
        add("point_1cyc",  1, 0, 0, 0, 0, 0, 1,               8'h01, 0, 0,  1, 0, 0, 0);
        add("sq_serve",    1, 1, 1, 0, 0, 0, 1,               8'h01, 1, 1,  0, 0, 0, 0);
        add("sq_pos6",     1, 1, 0, 0, 0, 0, 24,              8'h40, 1, 1,  0, 0, 0, 0);
        add("sq_ret2_ign", 1, 1, 0, 0, 1, 0, 4,               8'h80, 1, 1,  0, 0, 0, 0);
        add("sq_pre_wall", 1, 1, 0, 0, 0, 0, 3,               8'h80, 1, 1,  0, 0, 0, 0);
        add("sq_bounce",   1, 1, 0, 0, 0, 0, 1,               8'h40, 1, 0,  0, 0, 0, 0);
        add("sq_pos1",     1, 1, 0, 0, 0, 0, 20,              8'h02, 1, 0,  0, 0, 1, 0);
        add("sq_ret1",     1, 1, 0, 1, 0, 0, 1,               8'h02, 1, 1,  1, 0, 0, 0);
        add("match_p1",    1, 1, 0, 0, 0, 1, 1,               8'h00, 0, 0,  0, 0, 0, 0);
        add("idle_to_sw",  1, 1, 0, 0, 0, 0, 1,               8'h01, 0, 0,  0, 0, 0, 0);
        add("reserve",     1, 1, 1, 0, 0, 0, 1,               8'h01, 1, 1,  0, 0, 0, 0);
        add("mid_travel",  1, 1, 0, 0, 0, 0, 12,              8'h08, 1, 1,  0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst ball_pos", int'(ball_pos), 0);
        chk("rst ball_dir", int'(ball_dir), 1);
        chk("rst rally_cnt", int'(rally_cnt), 0);
        chk("rst point_over", int'(point_over), 0);
        chk("rst hittable", int'({hittable_p1, hittable_p2}), 0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vq[i]) begin
            apply(vq[i]);
            if (vq[i].name == "sq_ret1") chk("squash hittable_p2 seen", int'(saw_h2), 0);
        end

        // asynchronous reset between clock edges
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async ball_pos", int'(ball_pos), 0);
        chk("async ball_dir", int'(ball_dir), 1);
        chk("async rally_cnt", int'(rally_cnt), 0);
        chk("async hittable", int'({hittable_p1, hittable_p2}), 0);
        chk("async point_over", int'(point_over), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
